// File: rtl/dist_isqrt_unit_if.sv
// Start/busy/done handshake and point operands for the distance engine.
// master: request side (drives start, x1..y2); slave: engine side
// (drives busy, done, res).
interface dist_isqrt_unit_if #(
   parameter int COORD_W = 16
);
   logic               start;
   logic [COORD_W-1:0] x1;
   logic [COORD_W-1:0] y1;
   logic [COORD_W-1:0] x2;
   logic [COORD_W-1:0] y2;
   logic               busy;
   logic               done;
   logic [31:0]        res;

   modport master (
      output start, x1, y1, x2, y2,
      input  busy, done, res
   );

   modport slave (
      input  start, x1, y1, x2, y2,
      output busy, done, res
   );
endinterface

// File: rtl/dist_isqrt_unit.sv
// Sequential floor(sqrt((x2-x1)^2+(y2-y1)^2)), one root bit per cycle.
// Ports: clk_i, rst_i (sync, active-high), sif (slave: start/x1..y2 in,
// busy/done/res out). done is a 1-cycle pulse; res held until next done.
module dist_isqrt_unit #(
   parameter int COORD_W = 16
) (
   input logic              clk_i,
   input logic              rst_i,
   dist_isqrt_unit_if.slave sif
);
   localparam int SUM_W  = 2*COORD_W+2;
   localparam int ROOT_W = COORD_W+1;
   localparam int REM_W  = SUM_W/2+2;
   localparam int ITER_W = $clog2(ROOT_W);

   typedef enum logic [1:0] {
      ST_IDLE, ST_DIFF, ST_SQR, ST_ROOT
   } state_e;

   state_e              state_q, state_d;
   logic [COORD_W-1:0]  x1_q, y1_q, x2_q, y2_q;
   logic [COORD_W-1:0]  dx_q, dx_d, dy_q, dy_d;
   logic [SUM_W-1:0]    rad_q, rad_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [ROOT_W-1:0]   root_q, root_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [31:0]         res_q, res_d;
   logic                done_q, done_d;

   logic [REM_W-1:0]    rem_sh;
   logic [REM_W-1:0]    trial;
   logic                ge;
   logic [ROOT_W-1:0]   root_nx;
   logic [SUM_W-1:0]    dx_e, dy_e;
   logic                accept;

   assign accept = (state_q == ST_IDLE) && sif.start;

   // One restoring step: bring down the next radicand pair and try
   // appending a 1 to the partial root.
   assign rem_sh  = {rem_q[REM_W-3:0], rad_q[SUM_W-1 -: 2]};
   assign trial   = {root_q, 2'b01};
   assign ge      = rem_sh >= trial;
   assign root_nx = {root_q[ROOT_W-2:0], ge};
   assign dx_e    = SUM_W'(dx_q);
   assign dy_e    = SUM_W'(dy_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         x1_q    <= '0;
         y1_q    <= '0;
         x2_q    <= '0;
         y2_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         rad_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         iter_q  <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            x1_q <= sif.x1;
            y1_q <= sif.y1;
            x2_q <= sif.x2;
            y2_q <= sif.y2;
         end
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         rad_q   <= rad_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         iter_q  <= iter_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (sif.start) state_d = ST_DIFF;
         ST_DIFF: state_d = ST_SQR;
         ST_SQR:  state_d = ST_ROOT;
         ST_ROOT: if (iter_q == '0) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dx_d   = dx_q;
      dy_d   = dy_q;
      rad_d  = rad_q;
      rem_d  = rem_q;
      root_d = root_q;
      iter_d = iter_q;
      res_d  = res_q;
      done_d = 1'b0;
      unique case (state_q)
         ST_DIFF: begin
            dx_d = (x2_q >= x1_q) ? x2_q - x1_q : x1_q - x2_q;
            dy_d = (y2_q >= y1_q) ? y2_q - y1_q : y1_q - y2_q;
         end
         ST_SQR: begin
            rad_d  = dx_e*dx_e + dy_e*dy_e;
            rem_d  = '0;
            root_d = '0;
            iter_d = ITER_W'(ROOT_W-1);
         end
         ST_ROOT: begin
            rad_d  = rad_q << 2;
            rem_d  = ge ? rem_sh - trial : rem_sh;
            root_d = root_nx;
            if (iter_q == '0) begin
               res_d  = 32'(root_nx);
               done_d = 1'b1;
            end else begin
               iter_d = iter_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign sif.busy = (state_q != ST_IDLE);
   assign sif.done = done_q;
   assign sif.res  = res_q;
endmodule
